// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: forwarding-select encodings,
// instruction classes, opcode/funct values and the scoreboard entry with its helpers.
package hazard_pkg;

    localparam int REG_W = 5;

    typedef logic [2:0] fwd_sel_t;
    localparam fwd_sel_t FWD_NONE    = 3'd0;
    localparam fwd_sel_t FWD_MEM_ALU = 3'd1;
    localparam fwd_sel_t FWD_MEM_PC8 = 3'd2;
    localparam fwd_sel_t FWD_WB_WD   = 3'd3;
    localparam fwd_sel_t FWD_EX_PC8  = 3'd4;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_ALU  = 2'd1,
        CLS_LOAD = 2'd2,
        CLS_JAL  = 2'd3
    } iclass_e;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_ADDU   = 6'h21;
    localparam logic [5:0] FN_SUBU   = 6'h23;
    localparam logic [5:0] FN_AND    = 6'h24;
    localparam logic [5:0] FN_OR     = 6'h25;
    localparam logic [5:0] FN_SLT    = 6'h2a;

    // A source that is never read gets the largest Tuse, which no Tnew can exceed.
    localparam logic [1:0] TUSE_NONE = 2'd3;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] wa;
        iclass_e          cls;
        logic [1:0]       tnew;
    } sb_entry_t;

    function automatic logic sb_hit(input sb_entry_t e, input logic [REG_W-1:0] src);
        return e.valid && (e.cls != CLS_NONE) && (e.wa != '0) && (e.wa == src);
    endfunction

    function automatic sb_entry_t sb_age(input sb_entry_t e);
        sb_entry_t a;
        a      = e;
        a.tnew = (e.tnew == 2'd0) ? 2'd0 : e.tnew - 2'd1;
        return a;
    endfunction

    function automatic logic sb_stall(input logic [REG_W-1:0] src, input logic [1:0] tuse,
                                      input sb_entry_t e, input sb_entry_t m);
        return (sb_hit(e, src) && (e.tnew > tuse)) || (sb_hit(m, src) && (m.tnew > tuse));
    endfunction

    // M/W forwarding shared by ID and EX consumers; the younger M match decides even
    // when its value is not ready yet (the stall logic holds the consumer back).
    function automatic fwd_sel_t sb_mem_wb_sel(input logic [REG_W-1:0] src,
                                               input sb_entry_t m, input sb_entry_t w);
        fwd_sel_t sel;
        sel = FWD_NONE;
        if (sb_hit(m, src)) begin
            if (m.tnew == 2'd0 && m.cls == CLS_ALU)      sel = FWD_MEM_ALU;
            else if (m.tnew == 2'd0 && m.cls == CLS_JAL) sel = FWD_MEM_PC8;
        end else if (sb_hit(w, src) && w.tnew == 2'd0) begin
            sel = FWD_WB_WD;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational ID-stage decoder: extracts rs/rt, the destination register,
// instruction class, per-operand Tuse and the Tnew the result will have at ID.
module hazard_decode
    import hazard_pkg::*;
(
    input  logic [31:0]      i_instr,
    output logic [REG_W-1:0] o_rs,
    output logic [REG_W-1:0] o_rt,
    output logic [REG_W-1:0] o_wa,
    output iclass_e          o_cls,
    output logic [1:0]       o_tuse_rs,
    output logic [1:0]       o_tuse_rt,
    output logic [1:0]       o_tnew,
    output logic             o_store
);

    logic [5:0]       w_op;
    logic [5:0]       w_funct;
    logic [REG_W-1:0] w_rd;
    logic             w_unused_shamt;

    assign w_op           = i_instr[31:26];
    assign w_funct        = i_instr[5:0];
    assign w_rd           = i_instr[15:11];
    assign o_rs           = i_instr[25:21];
    assign o_rt           = i_instr[20:16];
    assign w_unused_shamt = ^i_instr[10:6];

    // NOTE: every output gets a default first, so no decode path can infer a latch.
    always_comb begin
        o_wa      = '0;
        o_cls     = CLS_NONE;
        o_tuse_rs = TUSE_NONE;
        o_tuse_rt = TUSE_NONE;
        o_store   = 1'b0;
        unique case (w_op)
            OP_RTYPE: begin
                unique case (w_funct)
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: begin
                        o_cls     = CLS_ALU;
                        o_wa      = w_rd;
                        o_tuse_rs = 2'd1;
                        o_tuse_rt = 2'd1;
                    end
                    FN_JR:   o_tuse_rs = 2'd0;
                    default: ;
                endcase
            end
            OP_ORI, OP_ADDIU: begin
                o_cls     = CLS_ALU;
                o_wa      = o_rt;
                o_tuse_rs = 2'd1;
            end
            OP_LUI: begin
                o_cls = CLS_ALU;
                o_wa  = o_rt;
            end
            OP_LW: begin
                o_cls     = CLS_LOAD;
                o_wa      = o_rt;
                o_tuse_rs = 2'd1;
            end
            OP_SW: begin
                o_tuse_rs = 2'd1;
                o_tuse_rt = 2'd2;
                o_store   = 1'b1;
            end
            OP_BEQ: begin
                o_tuse_rs = 2'd0;
                o_tuse_rt = 2'd0;
            end
            OP_BGTZ, OP_REGIMM: o_tuse_rs = 2'd0;
            OP_JAL: begin
                o_cls = CLS_JAL;
                o_wa  = 5'd31;
            end
            default: ;
        endcase
    end

    always_comb begin
        unique case (o_cls)
            CLS_ALU:  o_tnew = 2'd2;
            CLS_LOAD: o_tnew = 2'd3;
            CLS_JAL:  o_tnew = 2'd1;
            default:  o_tnew = 2'd0;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX/MEM/WB writer scoreboard, stall and forward selects.
// Optional stall-cycle counter port `stall_cnt` when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_ID,
    output logic        Stall,
    output logic [2:0]  CMPAfor,
    output logic [2:0]  CMPBfor,
    output logic [2:0]  Rafor,
    output logic [2:0]  ALUAfor,
    output logic [2:0]  ALUBfor,
    output logic [2:0]  RD2for,
    output logic [2:0]  DM_WDfor
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int RA_W = $clog2(NREG);

    logic [RA_W-1:0] w_rs;
    logic [RA_W-1:0] w_rt;
    logic [RA_W-1:0] w_wa;
    iclass_e         w_cls;
    logic [1:0]      w_tuse_rs;
    logic [1:0]      w_tuse_rt;
    logic [1:0]      w_tnew;
    logic            w_store;
    sb_entry_t       w_id_entry;

    sb_entry_t       r_e;
    sb_entry_t       r_m;
    sb_entry_t       r_w;
    logic [RA_W-1:0] r_e_ra1;
    logic [RA_W-1:0] r_e_ra2;
    logic            r_e_store;
    logic [RA_W-1:0] r_m_rt;
    logic            r_m_store;

    hazard_decode u_decode (
        .i_instr   (Instr_ID),
        .o_rs      (w_rs),
        .o_rt      (w_rt),
        .o_wa      (w_wa),
        .o_cls     (w_cls),
        .o_tuse_rs (w_tuse_rs),
        .o_tuse_rt (w_tuse_rt),
        .o_tnew    (w_tnew),
        .o_store   (w_store)
    );

    always_comb begin
        w_id_entry       = '0;
        w_id_entry.valid = (w_cls != CLS_NONE);
        w_id_entry.wa    = w_wa;
        w_id_entry.cls   = w_cls;
        w_id_entry.tnew  = w_tnew;
    end

    // NOTE: non-blocking assignments, so every stage shifts using its pre-edge neighbour.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_e       <= '0;
            r_m       <= '0;
            r_w       <= '0;
            r_e_ra1   <= '0;
            r_e_ra2   <= '0;
            r_e_store <= 1'b0;
            r_m_rt    <= '0;
            r_m_store <= 1'b0;
        end else begin
            r_e       <= Stall ? '0 : sb_age(w_id_entry);
            r_e_ra1   <= Stall ? '0 : w_rs;
            r_e_ra2   <= Stall ? '0 : w_rt;
            r_e_store <= Stall ? 1'b0 : w_store;
            r_m       <= sb_age(r_e);
            r_w       <= sb_age(r_m);
            r_m_rt    <= r_e_ra2;
            r_m_store <= r_e_store;
        end
    end

    assign Stall = sb_stall(w_rs, w_tuse_rs, r_e, r_m) | sb_stall(w_rt, w_tuse_rt, r_e, r_m);

    // In E only a JAL has its value (PC+8) ready; any other E match blocks older stages.
    function automatic fwd_sel_t id_sel(input logic [RA_W-1:0] src);
        fwd_sel_t sel;
        if (sb_hit(r_e, src)) begin
            sel = (r_e.tnew == 2'd0 && r_e.cls == CLS_JAL) ? FWD_EX_PC8 : FWD_NONE;
        end else begin
            sel = sb_mem_wb_sel(src, r_m, r_w);
        end
        return sel;
    endfunction

    assign CMPAfor  = id_sel(w_rs);
    assign Rafor    = id_sel(w_rs);
    assign CMPBfor  = id_sel(w_rt);
    assign ALUAfor  = sb_mem_wb_sel(r_e_ra1, r_m, r_w);
    assign ALUBfor  = sb_mem_wb_sel(r_e_ra2, r_m, r_w);
    assign RD2for   = sb_mem_wb_sel(r_e_ra2, r_m, r_w);
    assign DM_WDfor = (r_m_store && sb_hit(r_w, r_m_rt)) ? FWD_WB_WD : FWD_NONE;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (Stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It is the counterpart of the datapath's hazard-status interface: it consumes the ID-stage instruction and its own shadow copy of destination/Tnew state per stage, and drives `Stall` and every forwarding-select bus back into the datapath. It keeps a registered scoreboard of in-flight writers (EX/MEM/WB), decides stall-versus-forward each cycle, and optionally counts stall cycles.

## Interface
Parameters:
- `NREG`, 32: architectural register count; register 0 is never a hazard source.

Ports:
- `clk`  in  1  core clock
- `reset`  in  1  synchronous, active-low; `reset==0` at a rising edge clears all state
- `Instr_ID`  in  32  instruction currently in ID
- `Stall`  out  1  freeze IF/IF-ID, bubble ID/EX
- `CMPAfor`, `CMPBfor`, `Rafor`  out  3 each  ID-stage operand selects (rs, rt, jr target)
- `ALUAfor`, `ALUBfor`, `RD2for`  out  3 each  EX-stage operand selects
- `DM_WDfor`  out  3  MEM-stage store-data select
- `stall_cnt`  out  32  stall-cycle counter (present only with `HAZARD_PERF_CNT_EN`)

## Operation
- Decode from `Instr_ID`: rs, rt, WA (rd for R-type, rt for I-type, 31 for jal), write-enable, class ∈ {ALU, LOAD, JAL, NONE}, Tuse_rs, Tuse_rt.
- Tuse: beq/bgtz/bltz/jr rs/rt = 0; ALU/load/store base = 1; sw rt = 2; unused = 3 (never stalls).
- Tnew at ID: ALU = 2, LOAD = 3, JAL = 1, NONE = 0.
- Scoreboard entries E, M, W: {valid, wa[4:0], class, tnew[1:0]}. On every non-reset edge:
  - `Stall==0`: E ← decoded ID entry with tnew−1; `Stall==1`: E ← bubble (valid=0).
  - M ← E, W ← M; tnew decremented, saturating at 0.
- Match: entry valid, wa≠0, wa==source reg.
- Stall: any ID source with a match in E or M where entry.tnew > Tuse. Combinational from state and `Instr_ID`.
- Forward priority: youngest matching stage wins; a match with tnew>0 yields no forward (stall covers it).
- Select encodings (shared package): 0 FWD_NONE (GRF/pipeline value), 1 FWD_MEM_ALU, 2 FWD_MEM_PC8, 3 FWD_WB_WD, 4 FWD_EX_PC8.
  - ID selects: E JAL → 4; M ALU → 1; M JAL → 2; W → 3 (GRF write-through is not relied on).
  - EX selects (match against registered RA1/RA2 of E): M ALU → 1, M JAL → 2, W → 3.
  - DM_WDfor (rt of M store): W → 3; else 0.
- LOAD in M never forwards (tnew≥1 there); in W forwards via 3.

## Timing
- Scoreboard latency: one cycle per stage; outputs combinational from registers plus `Instr_ID`.
- Reset: E/M/W invalid, `Stall`=0, all selects 0, `stall_cnt`=0.
- Reset asserted during a stall: next cycle `Stall`=0 unless the post-reset `Instr_ID` itself hazards (it cannot: scoreboard empty).
- Back-to-back stalls: each stalled cycle inserts one bubble; stall releases exactly when tnew ≤ Tuse.
- Writes to $0 never stall or forward.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: `stall_cnt` port exists, increments by 1 every cycle `Stall==1`, wraps 0xFFFFFFFF→0, cleared by reset.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Package `hazard_pkg`: FWD_* encodings, class enum, opcode/funct constants, scoreboard-entry struct.
- Sub-module `hazard_decode`: pure combinational Instr → {rs, rt, wa, class, Tuse_rs, Tuse_rt, Tnew}.

## Test plan
- `lw $1,0($0)` then `addu $2,$1,$1` → one `Stall` cycle, then ALUAfor=ALUBfor=3.
- `lw $1` then `beq $1,$2` → two `Stall` cycles, then CMPAfor=3.
- `addu $3,$4,$5` then `beq $3,$3` → one stall, then CMPAfor=CMPBfor=1.
- `jal` then `jr $31` → no stall, Rafor=4.
- `ori $0,$0,5` then `addu $6,$0,$0` → no stall, selects 0.
- `HAZARD_PERF_CNT_EN`: three lw-use pairs → `stall_cnt`=3; reset low one cycle → 0.
